// File: rtl/trace_nop_event_decoder.sv
// trace_nop_event_decoder
//   Per-core monitor fed by the mor1kx execution trace port. Tracks a shadow
//   copy of r3 and turns simulation l.nop K instructions into events:
//   K=1 EXIT, K=2 REPORT, K=4 PUTC. Events are queued in a small FIFO drained
//   through a valid/ready port. A sticky exit flag and exit code are latched
//   for the system termination logic.
//
//   Optional build macro TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN adds a
//   free-running cycle counter whose value on the decode cycle is stored with
//   each event and presented on evt_timestamp.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   trace_valid/pc/insn  retired instruction beat
//   trace_wben/wbreg/wbdata  register writeback of that beat
//   evt_valid/evt_ready  event output handshake
//   evt_type, evt_data   head event (0 EXIT, 1 REPORT, 2 PUTC) and payload
//   evt_timestamp        (macro only) decode-cycle timestamp of head event
//   exited, exit_code    sticky exit flag and r3 value at exit
//   overflow_cnt         saturating count of events dropped on a full FIFO
module trace_nop_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,  // power of two, >= 2
  parameter int unsigned ID         = 0   // debug naming only
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_insn,
  input  logic        trace_wben,
  input  logic [4:0]  trace_wbreg,
  input  logic [31:0] trace_wbdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [31:0] evt_data,
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
  output logic [31:0] evt_timestamp,
`endif
  output logic        exited,
  output logic [31:0] exit_code,
  output logic [15:0] overflow_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
  localparam int unsigned EW = 66;
`else
  localparam int unsigned EW = 34;
`endif

  typedef enum logic {ST_RUN, ST_EXITED} state_e;
  typedef enum logic [1:0] {EVT_EXIT = 2'd0, EVT_REPORT = 2'd1, EVT_PUTC = 2'd2} evt_e;

  state_e      state_q, state_d;
  logic [31:0] r3_q, r3_d;
  logic        exited_q, exited_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic [15:0] ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
`endif

  logic          run, is_nop, evt_push, wr_en, pop, drop, full, empty;
  logic [15:0]   nop_k;
  evt_e          evt_kind;
  logic [31:0]   evt_payload;
  logic [AW:0]   fill;
  logic [EW-1:0] entry_d, head;

  // PC and the middle instruction byte carry no information for this decoder.
  logic unused_ok;
  assign unused_ok = ^{trace_pc, trace_insn[23:16], 32'(ID)};

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    run         = (state_q == ST_RUN);
    is_nop      = trace_valid && (trace_insn[31:24] == 8'h15);
    nop_k       = trace_insn[15:0];
    evt_push    = 1'b0;
    evt_kind    = EVT_EXIT;
    evt_payload = r3_q;
    if (run && is_nop) begin
      case (nop_k)
        16'd1: begin evt_push = 1'b1; evt_kind = EVT_EXIT;   end
        16'd2: begin evt_push = 1'b1; evt_kind = EVT_REPORT; end
        16'd4: begin
          evt_push    = 1'b1;
          evt_kind    = EVT_PUTC;
          evt_payload = {24'h0, r3_q[7:0]};
        end
        default: ;
      endcase
    end
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
    entry_d = {ts_q, evt_kind, evt_payload};
    ts_d    = ts_q + 32'd1;
`else
    entry_d = {evt_kind, evt_payload};
`endif

    // Extra pointer bit distinguishes full from empty.
    fill  = wr_ptr_q - rd_ptr_q;
    full  = (fill == (AW+1)'(FIFO_DEPTH));
    pop   = !empty && evt_ready;
    // A pop in the same cycle frees the slot the push lands in.
    wr_en = evt_push && (!full || pop);
    drop  = evt_push && !wr_en;

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = (drop && ovf_q != '1) ? ovf_q + 16'd1 : ovf_q;

    r3_d = r3_q;
    if (run && trace_valid && trace_wben && trace_wbreg == 5'd3)
      r3_d = trace_wbdata;

    // Exit is latched independently of the FIFO so a dropped EXIT is never lost.
    state_d     = state_q;
    exited_d    = exited_q;
    exit_code_d = exit_code_q;
    if (run && is_nop && nop_k == 16'd1) begin
      state_d     = ST_EXITED;
      exited_d    = 1'b1;
      exit_code_d = r3_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      r3_q        <= '0;
      exited_q    <= 1'b0;
      exit_code_q <= '0;
      ovf_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r3_q        <= r3_d;
      exited_q    <= exited_d;
      exit_code_q <= exit_code_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

  assign evt_valid    = !empty;
  assign evt_type     = empty ? '0 : head[33:32];
  assign evt_data     = empty ? '0 : head[31:0];
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
  assign evt_timestamp = empty ? '0 : head[65:34];
`endif
  assign exited       = exited_q;
  assign exit_code    = exit_code_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trace_nop_event_decoder.sv
module tb_trace_nop_event_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_insn;
  logic        trace_wben;
  logic [4:0]  trace_wbreg;
  logic [31:0] trace_wbdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_type;
  logic [31:0] evt_data;
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
  logic [31:0] evt_timestamp;
`endif
  logic        exited;
  logic [31:0] exit_code;
  logic [15:0] overflow_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  trace_nop_event_decoder #(.FIFO_DEPTH(8), .ID(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_insn   (trace_insn),
    .trace_wben   (trace_wben),
    .trace_wbreg  (trace_wbreg),
    .trace_wbdata (trace_wbdata),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_type     (evt_type),
    .evt_data     (evt_data),
`ifdef TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN
    .evt_timestamp(evt_timestamp),
`endif
    .exited       (exited),
    .exit_code    (exit_code),
    .overflow_cnt (overflow_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] insn, input logic wben,
                      input logic [4:0] wreg, input logic [31:0] wdata);
    trace_valid  = 1'b1;
    trace_pc     = trace_pc + 32'd4;
    trace_insn   = insn;
    trace_wben   = wben;
    trace_wbreg  = wreg;
    trace_wbdata = wdata;
    tick();
    trace_valid  = 1'b0;
    trace_wben   = 1'b0;
  endtask

  task automatic wr_r3(input logic [31:0] v);
    beat(32'hE000_0000, 1'b1, 5'd3, v);
  endtask

  task automatic nop(input logic [15:0] k);
    beat({16'h1500, k}, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trace_valid = 1'b0; trace_pc = '0; trace_insn = '0;
    trace_wben = 1'b0; trace_wbreg = '0; trace_wbdata = '0; evt_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_type", 32'(evt_type), 32'd0);
    check("rst_data", evt_data, 32'd0);
    check("rst_exited", 32'(exited), 32'd0);
    check("rst_code", exit_code, 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // PUTC latency, stability under backpressure, pop
    wr_r3(32'h41);
    check("r3wr_noevt", 32'(evt_valid), 32'd0);
    trace_valid = 1'b1; trace_insn = 32'h1500_0004;
    #1;
    check("putc_no_comb", 32'(evt_valid), 32'd0);
    tick();
    trace_valid = 1'b0;
    check("putc_valid", 32'(evt_valid), 32'd1);
    check("putc_type", 32'(evt_type), 32'd2);
    check("putc_data", evt_data, 32'h41);
    tick();
    check("putc_hold_valid", 32'(evt_valid), 32'd1);
    check("putc_hold_data", evt_data, 32'h41);
    pop_one();
    check("putc_popped", 32'(evt_valid), 32'd0);
    check("empty_data", evt_data, 32'd0);

    // REPORT uses r3 at decode; later r3 write leaves queued entry alone
    wr_r3(32'h5);
    nop(16'd2);
    check("rep_type", 32'(evt_type), 32'd1);
    check("rep_data", evt_data, 32'h5);
    wr_r3(32'h9);
    check("rep_data_kept", evt_data, 32'h5);
    pop_one();
    nop(16'd4);
    check("r3_upd_data", evt_data, 32'h9);
    pop_one();

    // Non-events
    nop(16'd3);
    check("k3_noevt", 32'(evt_valid), 32'd0);
    nop(16'd0);
    check("k0_noevt", 32'(evt_valid), 32'd0);
    beat(32'h1400_0004, 1'b0, 5'd0, 32'h0);
    check("nonnop_noevt", 32'(evt_valid), 32'd0);
    trace_insn = 32'h1500_0004;
    tick();
    check("novalid_noevt", 32'(evt_valid), 32'd0);
    beat(32'hE000_0000, 1'b1, 5'd4, 32'hBAD);
    nop(16'd4);
    check("other_reg_data", evt_data, 32'h9);
    pop_one();

    // Overflow: 10 pushes into 8 slots, PUTC masks to low byte
    for (int i = 0; i < 10; i++) begin
      wr_r3(32'h1A0 + 32'(i));
      nop(16'd4);
    end
    check("ovf_two", 32'(overflow_cnt), 32'd2);
    check("ovf_head", evt_data, 32'hA0);
    wr_r3(32'h1FF);
    evt_ready = 1'b1;
    nop(16'd4);
    evt_ready = 1'b0;
    check("full_pop_ovf", 32'(overflow_cnt), 32'd2);
    check("full_pop_head", evt_data, 32'hA1);
    evt_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("drain_valid", 32'(evt_valid), 32'd1);
      check("drain_data", evt_data, (j < 7) ? 32'hA1 + 32'(j) : 32'hFF);
      tick();
    end
    evt_ready = 1'b0;
    check("drain_empty", 32'(evt_valid), 32'd0);

    // EXIT, then EXITED ignores beats
    wr_r3(32'hCAFE_0001);
    nop(16'd1);
    check("exit_valid", 32'(evt_valid), 32'd1);
    check("exit_type", 32'(evt_type), 32'd0);
    check("exit_data", evt_data, 32'hCAFE_0001);
    check("exited", 32'(exited), 32'd1);
    check("exit_code", exit_code, 32'hCAFE_0001);
    nop(16'd4);
    wr_r3(32'h55);
    pop_one();
    check("exited_noevt", 32'(evt_valid), 32'd0);
    check("exit_code_kept", exit_code, 32'hCAFE_0001);

    // Async reset clears exit state and overflow immediately
    #2 rst = 1'b1;
    #1;
    check("arst_exited", 32'(exited), 32'd0);
    check("arst_code", exit_code, 32'd0);
    check("arst_ovf", 32'(overflow_cnt), 32'd0);
    #2 rst = 1'b0;
    tick();

    // r3 back to 0; reset with 3 queued events
    nop(16'd4);
    check("post_rst_valid", 32'(evt_valid), 32'd1);
    check("post_rst_r3", evt_data, 32'd0);
    nop(16'd4);
    nop(16'd4);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_type", 32'(evt_type), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("mid_rst_flushed", 32'(evt_valid), 32'd0);
    nop(16'd2);
    check("relat_valid", 32'(evt_valid), 32'd1);
    check("relat_type", 32'(evt_type), 32'd1);
    pop_one();

    // Dropped EXIT still latches exit and counts as overflow
    wr_r3(32'h77);
    for (int i = 0; i < 8; i++) nop(16'd4);
    check("fill_ovf", 32'(overflow_cnt), 32'd0);
    nop(16'd1);
    check("dexit_ovf", 32'(overflow_cnt), 32'd1);
    check("dexit_exited", 32'(exited), 32'd1);
    check("dexit_code", exit_code, 32'h77);
    check("dexit_head_type", 32'(evt_type), 32'd2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/trace_nop_event_decoder.md
Name: trace_nop_event_decoder

Overview:
- Per-core monitor stage fed directly by a compute tile's mor1kx execution trace port (one instance per core).
- Keeps a shadow copy of r3 and decodes simulation l.nop K instructions (exit, report, putc) into events.
- Buffers events in a small FIFO with a valid/ready output consumed by the stdout/termination logic.
- Latches a sticky exit flag and exit code for the system termination consensus.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- ID, 0, core index; not used in logic, carried for debug naming only.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- trace_valid  in  1  trace beat valid (one retired instruction).
- trace_pc  in  32  PC of the retired instruction.
- trace_insn  in  32  retired instruction word.
- trace_wben  in  1  register writeback enable.
- trace_wbreg  in  5  writeback register index.
- trace_wbdata  in  32  writeback data.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_type  out  2  event type: 0 EXIT, 1 REPORT, 2 PUTC.
- evt_data  out  32  event payload.
- exited  out  1  sticky: core executed exit nop.
- exit_code  out  32  r3 value at exit.
- overflow_cnt  out  16  dropped-event counter, saturating.

Behaviour:
- Reset (async assert, sync deassert by the integrator): r3 shadow=0, FIFO empty, evt_valid=0, evt_type=0, evt_data=0, exited=0, exit_code=0, overflow_cnt=0, state=RUN.
- r3 shadow update: on trace_valid & trace_wben & trace_wbreg==3, r3 <= trace_wbdata.
- Decode: nop when trace_valid & trace_insn[31:24]==8'h15; K=trace_insn[15:0].
  - K=1 gives EXIT.
  - K=2 gives REPORT.
  - K=4 gives PUTC.
  - Any other K, and any non-nop instruction: no event.
- Payload uses the registered r3 shadow value (pre-update for this beat). Nops never write r3.
  - EXIT and REPORT: evt_data=r3.
  - PUTC: evt_data={24'h0, r3[7:0]}.
- States:
  - RUN: decode active.
  - On an EXIT beat: enqueue the EXIT event; exited<=1 and exit_code<=r3 on the next edge; go to EXITED.
  - EXITED: all trace beats ignored (no r3 update, no events); left only by reset.
- Latency: an event decoded on cycle N appears at the FIFO head with evt_valid=1 at cycle N+1 if the FIFO was empty. Output is registered from the FIFO head, no combinational path from trace inputs.
- Handshake:
  - Pop on evt_valid & evt_ready.
  - evt_type and evt_data stay stable while evt_valid=1 and evt_ready=0.
  - evt_ready is ignored while evt_valid=0.
- FIFO boundaries:
  - Push while full with a same-cycle pop: accepted, occupancy unchanged.
  - Push while full with no pop: event dropped, overflow_cnt+1, saturating at 16'hFFFF.
  - Empty FIFO with evt_ready=1: no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH; an extra bit distinguishes full from empty.
- A dropped EXIT still sets exited and exit_code (exit is never lost) and still increments overflow_cnt.
- Reset mid-operation: FIFO contents discarded, all outputs return to reset values immediately.

Optional Feature:
- Macro: TRACE_NOP_EVENT_DECODER_TIMESTAMP_EN.
- Defined:
  - Adds port evt_timestamp out 32: value of a free-running 32-bit cycle counter sampled on the decode cycle.
  - Counter resets to 0, increments every clk, wraps at 2^32.
  - Timestamp is stored per FIFO entry alongside type and data.
- Undefined: no counter, no evt_timestamp port, FIFO width 34 bits.

Test Plan:
- Write r3=0x41 (wben, wbreg=3), then insn 0x15000004 → one event, type=2, data=0x00000041, evt_valid high one cycle after the nop beat.
- Write r3=0x0, then insn 0x15000001, evt_ready=1 → EXIT event data=0. Next cycle exited=1, exit_code=0. A subsequent 0x15000004 produces no event.
- Same-cycle check: insn 0x15000002 with r3 shadow=0x5 → REPORT data=0x5; a later r3 write of 0x9 does not alter the queued entry.
- evt_ready=0, issue 10 PUTC nops with FIFO_DEPTH=8 → 8 events held, overflow_cnt=2. Then drain 8 in order, with payloads matching issue order.
- FIFO full with evt_ready=1 and a new PUTC in the same cycle → accepted, overflow_cnt unchanged, occupancy stays 8.
- Assert rst with 3 events queued → evt_valid=0, overflow_cnt=0, exited=0 at once. After release, the first new event has latency 1.
